// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Contents:
//   rx_state_t         receiver FSM state encoding
//   OVERSAMPLE         ticks per bit period
//   SAMPLE_MID         tick index of the start-bit centre (counting from 0)
//   DATA_BITS          payload bits per frame
//   SAMPLE_W / BIT_W   widths of the tick-within-bit and bit-index counters
//   tick_divisor()     oversample divisor derived from core clock and line rate
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned SAMPLE_MID = 7;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned SAMPLE_W   = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W      = $clog2(DATA_BITS);

    // Terminal count of the tick counter: one tick every (divisor + 1) clocks.
    function automatic int unsigned tick_divisor(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        return clk_freq / (baud_rate * OVERSAMPLE) - 1;
    endfunction

endpackage

// File: rtl/uart_oversample_ticker.sv
// Oversample tick generator: counts 0..divisor and pulses tick for one clock
// on each wrap. clear restarts the count so the receiver's tick phase lines
// up with a detected start edge.
// Ports:
//   clk    in   core clock
//   reset  in   asynchronous, active-high reset
//   clear  in   restart the count from 0 (suppresses any tick next cycle)
//   tick   out  one-clock pulse, OVERSAMPLE times per bit period
module uart_oversample_ticker #(
    parameter int unsigned divisor = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (divisor < 1) ? 1 : $clog2(divisor + 1);

    logic [CNT_W-1:0] cnt;

    // Divisor counter; wraps only on reaching the terminal count or on clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CNT_W'(divisor)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: recovers 8N1 frames (8E1 when UART_RX_PARITY_EN is defined)
// from the asynchronous serial line using 16x oversampling and mid-bit
// sampling, and presents each byte through a valid/ready holding register.
// Configuration macro: UART_RX_PARITY_EN adds an even-parity bit after the
// data bits and the parity_error output.
// Ports:
//   clk            in   core clock
//   reset          in   asynchronous, active-high reset
//   rx             in   serial line, asynchronous to clk, idle high
//   data           out  received byte, meaningful while data_valid=1
//   data_valid     out  holding register full
//   data_ready     in   consumer accepts the held byte
//   framing_error  out  one-clock pulse: stop bit sampled low
//   overrun_error  out  one-clock pulse: byte completed while holding reg full
//   parity_error   out  one-clock pulse: even-parity mismatch (parity build only)
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned clk_freq  = 100000000,
    parameter int unsigned baud_rate = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       framing_error,
    output logic       overrun_error
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_error
`endif
);

    localparam int unsigned DIVISOR = tick_divisor(clk_freq, baud_rate);

    rx_state_t              state, state_n;
    logic [SAMPLE_W-1:0]    sample_cnt, sample_cnt_n;
    logic [BIT_W-1:0]       bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0]   shift, shift_n;
    logic                   rx_meta, rx_s, rx_prev;
    logic                   tick;
    logic                   clear_c;
    logic                   commit_c;
    logic                   frame_err_c;
`ifdef UART_RX_PARITY_EN
    logic                   parity_bad, parity_bad_n;
    logic                   par_err_c;
`endif

    // Tick generator, phase-aligned to each start edge.
    uart_oversample_ticker #(
        .divisor (DIVISOR)
    ) u_ticker (
        .clk   (clk),
        .reset (reset),
        .clear (clear_c),
        .tick  (tick)
    );

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // FSM state and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
`ifdef UART_RX_PARITY_EN
            parity_bad <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            sample_cnt <= sample_cnt_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
`ifdef UART_RX_PARITY_EN
            parity_bad <= parity_bad_n;
`endif
        end
    end

    // Next-state and sampling decisions; sample_cnt counts ticks within a bit.
    always_comb begin
        state_n      = state;
        sample_cnt_n = sample_cnt;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        clear_c      = 1'b0;
        commit_c     = 1'b0;
        frame_err_c  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_n = parity_bad;
        par_err_c    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rx_prev && !rx_s) begin
                    state_n      = START;
                    sample_cnt_n = '0;
                    clear_c      = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (sample_cnt == SAMPLE_W'(SAMPLE_MID)) begin
                        // A start bit that is high again at its centre was a glitch.
                        if (rx_s) begin
                            state_n = IDLE;
                        end else begin
                            state_n      = DATA;
                            sample_cnt_n = '0;
                            bit_cnt_n    = '0;
                        end
                    end else begin
                        sample_cnt_n = sample_cnt + SAMPLE_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (sample_cnt == SAMPLE_W'(OVERSAMPLE - 1)) begin
                        sample_cnt_n = '0;
                        shift_n      = {rx_s, shift[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            bit_cnt_n = bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        sample_cnt_n = sample_cnt + SAMPLE_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (sample_cnt == SAMPLE_W'(OVERSAMPLE - 1)) begin
                        sample_cnt_n = '0;
                        // Even parity: data bits plus parity bit must have an even count of ones.
                        parity_bad_n = (^shift) ^ rx_s;
                        state_n      = STOP;
                    end else begin
                        sample_cnt_n = sample_cnt + SAMPLE_W'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (sample_cnt == SAMPLE_W'(OVERSAMPLE - 1)) begin
                        sample_cnt_n = '0;
                        if (rx_s) begin
                            state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                            commit_c  = !parity_bad;
                            par_err_c = parity_bad;
`else
                            commit_c  = 1'b1;
`endif
                        end else begin
                            // Framing error wins over parity; the line must return high first.
                            frame_err_c = 1'b1;
                            state_n     = BREAK;
                        end
                    end else begin
                        sample_cnt_n = sample_cnt + SAMPLE_W'(1);
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Holding register: a drain in the commit cycle frees room for the new byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data          <= '0;
            data_valid    <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            overrun_error <= 1'b0;
            if (commit_c) begin
                if (!data_valid || data_ready) begin
                    data       <= shift;
                    data_valid <= 1'b1;
                end else begin
                    overrun_error <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

    // Registered error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error  <= 1'b0;
`endif
        end else begin
            framing_error <= frame_err_c;
`ifdef UART_RX_PARITY_EN
            parity_error  <= par_err_c;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 64 clocks per bit (4 clocks per tick).
// Expected bytes are queued as frames are driven and compared as the DUT
// hands them over; error pulses are counted and checked per scenario.
module tb_uart_rx;

    localparam int unsigned BIT_CLK = 64;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;
    logic       framing_error;
    logic       overrun_error;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
`endif

    logic [7:0] exp_q[$];
    int         check_cnt;
    int         pass_cnt;
    int         xfer_cnt;
    int         push_cnt;
    int         fe_cnt;
    int         ov_cnt;
    int         pe_cnt;

    uart_rx #(
        .clk_freq  (6400),
        .baud_rate (100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx),
        .data          (data),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .overrun_error (overrun_error)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_error  (parity_error)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard side: every handshake must match the oldest queued byte.
    always @(negedge clk) begin
        if (!reset && data_valid && data_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_xfer", 32'(data), 32'hFFFF_FFFF);
            end else begin
                check("data", 32'(data), 32'(exp_q.pop_front()));
            end
        end
        if (framing_error) fe_cnt++;
        if (overrun_error) ov_cnt++;
`ifdef UART_RX_PARITY_EN
        if (parity_error) pe_cnt++;
`endif
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLK) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit expect_byte);
        if (expect_byte) begin
            exp_q.push_back(b);
            push_cnt++;
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^b);
`endif
        drive_bit(1'b1);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] b, input logic par, input bit expect_byte);
        if (expect_byte) begin
            exp_q.push_back(b);
            push_cnt++;
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(par);
        drive_bit(1'b1);
    endtask
`endif

    // Bounded wait for the scoreboard to empty; then valid must be low.
    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check({tag, "_valid_low"}, 32'(data_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fe0, ov0, xf0, pe0;
        check_cnt = 0; pass_cnt = 0; xfer_cnt = 0; push_cnt = 0;
        fe_cnt = 0; ov_cnt = 0; pe_cnt = 0;
        rx = 1'b1;
        data_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(data), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_fe", 32'(framing_error), 32'd0);
        check("rst_ov", 32'(overrun_error), 32'd0);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // 1: single frame, consumer always ready
        xf0 = xfer_cnt;
        send_frame(8'h55, 1'b1);
        wait_drain("t1", 200);
        check("t1_xfers", 32'(xfer_cnt - xf0), 32'd1);
        check("t1_fe", 32'(fe_cnt), 32'd0);
        check("t1_ov", 32'(ov_cnt), 32'd0);

        // 2: back-to-back frames into a stalled consumer
        data_ready = 1'b0;
        ov0 = ov_cnt;
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b0);
        check("t2_ov", 32'(ov_cnt - ov0), 32'd1);
        check("t2_valid_held", 32'(data_valid), 32'd1);
        check("t2_data_held", 32'(data), 32'hA3);
        data_ready = 1'b1;
        wait_drain("t2", 50);

        // 3: short glitch on the line is rejected
        xf0 = xfer_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
        rx = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (4 * BIT_CLK) @(posedge clk);
        #1;
        check("t3_xfers", 32'(xfer_cnt - xf0), 32'd0);
        check("t3_fe", 32'(fe_cnt - fe0), 32'd0);
        check("t3_ov", 32'(ov_cnt - ov0), 32'd0);

        // 4: held-low break then a good frame
        fe0 = fe_cnt;
        rx = 1'b0;
        repeat (20 * BIT_CLK) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (2 * BIT_CLK) @(posedge clk);
        #1;
        check("t4_fe", 32'(fe_cnt - fe0), 32'd1);
        send_frame(8'h7E, 1'b1);
        wait_drain("t4", 200);
        check("t4_fe_after", 32'(fe_cnt - fe0), 32'd1);

        // 5: reset mid-frame with a byte still held
        data_ready = 1'b0;
        send_frame(8'h3C, 1'b0);
        check("t5_pre_valid", 32'(data_valid), 32'd1);
        check("t5_pre_data", 32'(data), 32'h3C);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx = 1'b0;
        repeat (BIT_CLK / 2) @(posedge clk);
        #1;
        reset = 1'b1;
        rx = 1'b1;
        #2;
        check("t5_rst_data", 32'(data), 32'd0);
        check("t5_rst_valid", 32'(data_valid), 32'd0);
        check("t5_rst_fe", 32'(framing_error), 32'd0);
        check("t5_rst_ov", 32'(overrun_error), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        data_ready = 1'b1;
        fe0 = fe_cnt; xf0 = xfer_cnt;
        repeat (2 * BIT_CLK) @(posedge clk);
        #1;
        check("t5_no_xfer", 32'(xfer_cnt - xf0), 32'd0);
        send_frame(8'h81, 1'b1);
        wait_drain("t5", 200);
        check("t5_fe", 32'(fe_cnt - fe0), 32'd0);

`ifdef UART_RX_PARITY_EN
        // 6: parity mismatch drops the byte; correct parity delivers it
        pe0 = pe_cnt; xf0 = xfer_cnt;
        send_frame_par(8'h01, 1'b0, 1'b0);
        repeat (BIT_CLK) @(posedge clk);
        #1;
        check("t6_pe", 32'(pe_cnt - pe0), 32'd1);
        check("t6_no_xfer", 32'(xfer_cnt - xf0), 32'd0);
        send_frame_par(8'h01, 1'b1, 1'b1);
        wait_drain("t6", 200);
        check("t6_pe_after", 32'(pe_cnt - pe0), 32'd1);
`else
        pe0 = pe_cnt;
        check("no_parity_pulses", 32'(pe0), 32'd0);
`endif

        check("total_xfers", 32'(xfer_cnt), 32'(push_cnt));
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
